// File: rtl/quiz_pkg.sv
// Shared constants for the quiz controller: key channel indices and board defaults.
// Imported by key_debounce_bank and by anything that needs to name a key by role.
package quiz_pkg;

    // Key channel indices into key_raw / key_level / key_rise / key_fall.
    localparam int unsigned KEY_K1    = 0;
    localparam int unsigned KEY_K2    = 1;
    localparam int unsigned KEY_K3    = 2;
    localparam int unsigned KEY_K4    = 3;
    localparam int unsigned KEY_OK    = 4;
    localparam int unsigned KEY_STOP  = 5;
    localparam int unsigned KEY_ADD   = 6;
    localparam int unsigned KEY_RESET = 7;

    localparam int unsigned N_KEYS_DEFAULT = 8;

    // 10 ms of bounce rejection at the 50 MHz board clock.
    localparam int unsigned DB_CYCLES_50MHZ = 500000;

endpackage : quiz_pkg

// File: rtl/key_debounce_cell.sv
// Single key channel: polarity correction, two-flop synchroniser, bounce
// counter, debounced level and registered one-cycle rise/fall pulses.
// With KEY_REPEAT_EN defined, a held key also emits repeat rise pulses.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   key_raw    unsynchronised button input
//   key_level  debounced active-high level
//   key_rise   one-cycle pulse on accepted press (and on repeats if enabled)
//   key_fall   one-cycle pulse on accepted release
//   cnt_nz_c   debounce counter is non-zero (combinational from flops)
module key_debounce_cell #(
    parameter int unsigned DB_CYCLES     = 4,
    parameter bit          ACTIVE_LOW    = 1'b0
`ifdef KEY_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY  = 10,
    parameter int unsigned REPEAT_PERIOD = 3
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_level,
    output logic key_rise,
    output logic key_fall,
    output logic cnt_nz_c
);

    localparam int unsigned CNT_W = $clog2(DB_CYCLES);

    logic             key_in_c;
    logic             accept_c;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef KEY_REPEAT_EN
    localparam int unsigned HOLD_W = $clog2(REPEAT_DELAY + 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
`endif

    assign key_in_c = key_raw ^ ACTIVE_LOW;

    // Synchronised input has differed from the stable value for DB_CYCLES edges.
    assign accept_c = (sync2_q != stable_q) && (cnt_q == CNT_W'(DB_CYCLES - 1));

    // Next-state: synchroniser shift, bounce counter, pulse generation.
    always_comb begin
        sync1_d  = key_in_c;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        rise_d   = 1'b0;
        fall_d   = 1'b0;

        if (accept_c) begin
            stable_d = sync2_q;
            rise_d   = sync2_q;
            fall_d   = ~sync2_q;
        end else if (sync2_q != stable_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

`ifdef KEY_REPEAT_EN
        // Hold counter restarts at the press pulse; after the first repeat it is
        // rewound so the next firing lands REPEAT_PERIOD edges later. No repeat
        // is issued on the edge that accepts the release.
        hold_d = '0;
        if (stable_q && !accept_c) begin
            if (hold_q == HOLD_W'(REPEAT_DELAY - 1)) begin
                hold_d = HOLD_W'(REPEAT_DELAY - REPEAT_PERIOD);
                rise_d = 1'b1;
            end else begin
                hold_d = hold_q + HOLD_W'(1);
            end
        end
`endif
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

`ifdef KEY_REPEAT_EN
    // Repeat hold counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    assign key_level = stable_q;
    assign key_rise  = rise_q;
    assign key_fall  = fall_q;
    assign cnt_nz_c  = |cnt_q;

endmodule : key_debounce_cell

// File: rtl/key_debounce_bank.sv
// Bank of independent key debouncers feeding the buzzer-lock / scoring logic.
// Optional key auto-repeat is enabled by defining KEY_REPEAT_EN.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   key_raw    unsynchronised button inputs, one bit per key
//   key_level  debounced active-high key state
//   key_rise   one-cycle pulse when a key is accepted as pressed
//   key_fall   one-cycle pulse when a key is accepted as released
//   key_busy   any channel has a non-zero debounce counter
module key_debounce_bank
    import quiz_pkg::*;
#(
    parameter int unsigned N_KEYS        = N_KEYS_DEFAULT,
    parameter int unsigned DB_CYCLES     = DB_CYCLES_50MHZ,
    parameter bit          ACTIVE_LOW    = 1'b0,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_rise,
    output logic [N_KEYS-1:0] key_fall,
    output logic              key_busy
);

    // Elaboration-time parameter sanity.
    if (DB_CYCLES < 2) begin : g_bad_db_cycles
        $error("key_debounce_bank: DB_CYCLES must be at least 2");
    end
    if (REPEAT_PERIOD == 0 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_repeat
        $error("key_debounce_bank: need 0 < REPEAT_PERIOD <= REPEAT_DELAY");
    end

    logic [N_KEYS-1:0] cnt_nz_c;

    // One debounce channel per key.
    for (genvar i = 0; i < N_KEYS; i++) begin : g_cell
        key_debounce_cell #(
            .DB_CYCLES     (DB_CYCLES),
            .ACTIVE_LOW    (ACTIVE_LOW)
`ifdef KEY_REPEAT_EN
            ,
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
        ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .key_raw   (key_raw[i]),
            .key_level (key_level[i]),
            .key_rise  (key_rise[i]),
            .key_fall  (key_fall[i]),
            .cnt_nz_c  (cnt_nz_c[i])
        );
    end

    assign key_busy = |cnt_nz_c;

endmodule : key_debounce_bank

// File: tb/tb_key_debounce_bank.sv
// Self-checking bench for key_debounce_bank: one active-high and one
// active-low instance, DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
module tb_key_debounce_bank;
    import quiz_pkg::*;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam int LAT = DB + 1;   // step index (0-based) at which a change becomes visible

    typedef struct {
        bit         sel;    // 0: active-high DUT, 1: active-low DUT
        logic [7:0] raw;
        logic [7:0] level;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       busy;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [7:0] key_raw,   key_level,   key_rise,   key_fall;
    logic [7:0] key_raw_b, key_level_b, key_rise_b, key_fall_b;
    logic       key_busy,  key_busy_b;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    key_debounce_bank #(
        .N_KEYS(8), .DB_CYCLES(DB), .ACTIVE_LOW(1'b0),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) u_dut (
        .clk(clk), .rst(rst), .key_raw(key_raw), .key_level(key_level),
        .key_rise(key_rise), .key_fall(key_fall), .key_busy(key_busy)
    );

    key_debounce_bank #(
        .N_KEYS(8), .DB_CYCLES(DB), .ACTIVE_LOW(1'b1),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) u_dut_b (
        .clk(clk), .rst(rst), .key_raw(key_raw_b), .key_level(key_level_b),
        .key_rise(key_rise_b), .key_fall(key_fall_b), .key_busy(key_busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input vec_t e);
        logic [24:0] act;
        logic [24:0] exp;
        if (e.sel) act = {key_level_b, key_rise_b, key_fall_b, key_busy_b};
        else       act = {key_level,   key_rise,   key_fall,   key_busy};
        exp = {e.level, e.rise, e.fall, e.busy};
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s sel=%0d raw=%h: got level=%h rise=%h fall=%h busy=%b, expected level=%h rise=%h fall=%h busy=%b",
                     name, e.sel, e.raw, act[24:17], act[16:9], act[8:1], act[0],
                     e.level, e.rise, e.fall, e.busy);
        end
    endtask

    // Press `mask` (active-high sense) from an all-released, settled state,
    // hold for n_hold steps, release for n_rel steps.
    task automatic add_press(input bit sel, input logic [7:0] mask, input int n_hold, input int n_rel);
        for (int t = 0; t < n_hold + n_rel; t++) begin
            vec_t       v;
            logic [7:0] phys;
            phys    = (t < n_hold) ? mask : 8'h00;
            v.sel   = sel;
            v.raw   = sel ? ~phys : phys;
            v.level = (t >= LAT && t < n_hold + LAT) ? mask : 8'h00;
            v.rise  = (t == LAT) ? mask : 8'h00;
            v.fall  = (t == n_hold + LAT) ? mask : 8'h00;
            v.busy  = (t >= 2 && t <= LAT - 1) || (t >= n_hold + 2 && t <= n_hold + LAT - 1);
`ifdef KEY_REPEAT_EN
            if (t > LAT && t < n_hold + LAT && (t - LAT) >= RD && ((t - LAT - RD) % RP) == 0)
                v.rise = mask;
`endif
            vecs.push_back(v);
        end
    endtask

    // Key K3 bounces 1,1,0,0,1,1,0,0 then holds 1 for 9 steps, then releases.
    task automatic add_bounce();
        logic [7:0] bpat;
        logic [7:0] m;
        bpat = 8'b0011_0011;
        m    = 8'(1) << KEY_K3;
        for (int t = 0; t < 25; t++) begin
            vec_t v;
            logic b;
            b       = (t < 8) ? bpat[t] : (t < 17);
            v.sel   = 1'b0;
            v.raw   = b ? m : 8'h00;
            v.level = (t >= 13 && t <= 21) ? m : 8'h00;
            v.rise  = (t == 13) ? m : 8'h00;
            v.fall  = (t == 22) ? m : 8'h00;
            v.busy  = (t inside {2, 3, 6, 7, 10, 11, 12, 19, 20, 21});
            vecs.push_back(v);
        end
    endtask

    // Apply queued vectors one per clock; called just after a negedge.
    task automatic run_vectors();
        int idx;
        idx = 0;
        while (vecs.size() > 0) begin
            vec_t v;
            vec_t e;
            v = vecs.pop_front();
            if (v.sel) begin
                key_raw_b = v.raw;
                key_raw   = 8'h00;
            end else begin
                key_raw   = v.raw;
                key_raw_b = 8'hFF;
            end
            exp_q.push_back(v);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check($sformatf("vec%0d", idx), e);
            idx++;
            @(negedge clk);
        end
    endtask

    initial begin
        vec_t z;
        z.sel = 1'b0; z.raw = 8'hFF; z.level = '0; z.rise = '0; z.fall = '0; z.busy = 1'b0;

        // Reset held with every key pressed: all outputs stay 0.
        rst       = 1'b0;
        key_raw   = 8'hFF;
        key_raw_b = 8'hFF;
        repeat (3) @(negedge clk);
        check("reset_a", z);
        z.sel = 1'b1;
        check("reset_b", z);

        // Release reset while holding all keys, then the directed scenarios.
        rst = 1'b1;
        add_press(1'b0, 8'hFF, 8, 8);
        add_press(1'b0, 8'(1) << KEY_K1, 20, 8);
        add_bounce();
        add_press(1'b0, (8'(1) << KEY_K2) | (8'(1) << KEY_K4), 8, 8);
        add_press(1'b0, 8'(1) << KEY_ADD, 30, 8);
        add_press(1'b1, 8'(1) << KEY_STOP, 8, 8);
        run_vectors();

        // Reset mid-count discards the partial count.
        key_raw   = 8'(1) << KEY_OK;
        key_raw_b = 8'hFF;
        repeat (4) @(posedge clk);
        #1;
        z.sel = 1'b0; z.raw = key_raw; z.busy = 1'b1;
        check("midcount_busy", z);
        #2;
        rst = 1'b0;
        #1;
        z.busy = 1'b0;
        check("midcount_reset", z);
        @(negedge clk);
        rst = 1'b1;
        add_press(1'b0, 8'(1) << KEY_OK, 8, 8);
        run_vectors();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_key_debounce_bank

// File: doc/key_debounce_bank.md
Name: key_debounce_bank

Overview:
- Conditions raw push-button inputs before the quiz controller sees them. The inputs are k1..k4, ok, stop, add and reset.
- Per key: synchronises the input to clk, filters contact bounce, and outputs a clean level plus one-cycle rise and fall pulses.
- Sits directly upstream of the buzzer-lock / scoring logic. That logic consumes key_rise for first-press arbitration and for score increments, instead of using raw levels or raw-key clock edges.

Parameters:
- N_KEYS, 8, number of independent key channels.
- DB_CYCLES, 500000, clk cycles a synchronised input must differ from the stable value before it is accepted (10 ms at 50 MHz). Legal range is 2 or more.
- ACTIVE_LOW, 0, when 1 every raw input is inverted at entry, so key_level is always active-high.
- REPEAT_DELAY, 25000000, hold time before the first repeat pulse. Used only with KEY_REPEAT_EN.
- REPEAT_PERIOD, 5000000, spacing of subsequent repeat pulses. Used only with KEY_REPEAT_EN.

Ports:
- clk  input  1  system clock; all state is clocked on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- key_raw  input  N_KEYS  unsynchronised button inputs, one bit per key.
- key_level  output  N_KEYS  debounced, active-high key state.
- key_rise  output  N_KEYS  one-cycle pulse when a key is accepted as pressed.
- key_fall  output  N_KEYS  one-cycle pulse when a key is accepted as released.
- key_busy  output  1  OR over all channels of "debounce counter non-zero"; used for bench and status.

Behaviour:
- Reset (rst=0, asynchronous):
  - sync FFs are cleared to the inactive level (0 after polarity correction);
  - stable = 0, cnt = 0;
  - key_level, key_rise, key_fall and key_busy are all 0.
  - Deassertion of rst takes effect on the next clk edge.
- Entry: in = key_raw XOR {N_KEYS{ACTIVE_LOW}}.
- Synchroniser: two-FF chain per bit, sync1 <= in, sync2 <= sync1.
- Per-channel counter:
  - width $clog2(DB_CYCLES);
  - counts only while sync2 != stable.
- Each clk edge, per channel:
  - If sync2 == stable: cnt <= 0, no pulse.
  - Else if cnt == DB_CYCLES-1: stable <= sync2, cnt <= 0. In the same cycle key_rise (if sync2=1) or key_fall (if sync2=0) is registered high.
  - Else: cnt <= cnt+1.
- Pulse outputs are registered and high for exactly one cycle. That cycle is the first cycle in which the new key_level is visible.
- key_level = stable.
- Latency: a clean raw edge appears on key_level and the pulse after DB_CYCLES+2 clk edges. With DB_CYCLES=4 this is 6 edges.
- Bounce: any glitch shorter than DB_CYCLES cycles (measured at sync2) clears cnt. No level change and no pulse results. The filter restarts on every return to the stable value.
- Channels are fully independent:
  - simultaneous presses on several keys yield simultaneous rise pulses in the same cycle;
  - no priority is applied here (arbitration belongs to the consumer).
- A key held indefinitely yields exactly one rise pulse (feature disabled). Release yields exactly one fall pulse.
- Reset mid-count discards partial counts. A key held through reset release is accepted DB_CYCLES+2 edges after rst rises, with a rise pulse.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - each channel adds a hold counter of width $clog2(REPEAT_DELAY+1), cleared whenever stable=0;
  - while stable=1, after REPEAT_DELAY cycles following the rise pulse, an extra key_rise pulse is emitted;
  - further pulses follow every REPEAT_PERIOD cycles until release;
  - key_fall is unaffected;
  - this lets the add key step scores by holding the button.
- Undefined: hold counters and repeat logic are absent, and key_rise fires once per accepted press.

Decomposition:
- Shared package quiz_pkg holds:
  - key index localparams KEY_K1=0, KEY_K2=1, KEY_K3=2, KEY_K4=3, KEY_OK=4, KEY_STOP=5, KEY_ADD=6, KEY_RESET=7;
  - the default DB_CYCLES for the 50 MHz board clock.
- One sub-module, key_debounce_cell: a single channel with its synchroniser, counter, pulse registers and optional repeat logic. It is instantiated N_KEYS times via generate.
- key_busy is the OR reduction done in the top level.

Test Plan (DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, N_KEYS=8):
- Reset: rst=0 with key_raw=8'hFF → all outputs 0. Release rst while holding → key_level=FF and key_rise=FF for one cycle, 6 edges after rst rises.
- Clean press: key_raw[0] 0→1 held 20 cycles → key_rise[0] high exactly one cycle at edge 6; key_level[0]=1 thereafter; no other bits change.
- Bounce: key_raw[2] toggles 1,0,1,0 with 2-cycle widths, then stays 1 → no pulse during the bounce; a single key_rise[2] occurs 6 edges after the final rising edge.
- Simultaneous: key_raw[3] and key_raw[1] rise in the same cycle → key_rise=8'h0A in a single cycle. Release both → key_fall=8'h0A in a single cycle.
- ACTIVE_LOW=1: key_raw idles at FF, bit 5 pulled low → key_rise[5] after 6 edges; release gives key_fall[5].
- KEY_REPEAT_EN: hold key_raw[6] for 30 cycles → rise pulses at relative cycles 0, 10, 13, 16, …; none after release; one key_fall[6].
